// File: rtl/demux_rr_scheduler.sv
// rtl/demux_rr_scheduler.sv - round-robin owner of the shared 1-to-16 demux select/enable
// Demux select s drives out[15-s], so the owner index is inverted onto out_sel.
module demux_rr_scheduler #(
  parameter int TIMEOUT      = 255,
  parameter int GUARD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] input_req,
  input  logic        input_done,
  output logic [3:0]  out_sel,
  output logic        out_e,
  output logic [15:0] out_grant,
  output logic        out_busy,
  output logic        out_timeout
);

  typedef enum logic [1:0] {IDLE, SETUP, GRANT, GUARD} state_t;

  localparam logic [7:0] TO_LIMIT   = 8'(TIMEOUT);
  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES);

  state_t      state;
  logic [3:0]  ptr;
  logic [3:0]  owner;
  logic [7:0]  timer;
  logic [3:0]  gcnt;

  logic [3:0]  next_idx;
  logic [3:0]  cand;
  logic        found;
  logic        owner_req;
  logic        to_hit;
  logic        grant_exit;
  logic        to_only;

  // Search starts just past the last owner, so a held request waits at most 15 grants.
  always_comb begin
    next_idx = ptr;
    cand     = ptr;
    found    = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cand = ptr + 4'(k);
      if (!found && input_req[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

  always_comb begin
    owner_req  = input_req[owner];
    to_hit     = (TO_LIMIT != 8'd0) && (timer == TO_LIMIT);
    grant_exit = input_done || !owner_req || to_hit;
    to_only    = to_hit && !input_done && owner_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      out_sel     <= 4'd0;
      out_e       <= 1'b0;
      out_grant   <= 16'd0;
      out_busy    <= 1'b0;
      out_timeout <= 1'b0;
      ptr         <= 4'hF;
      owner       <= 4'd0;
      timer       <= 8'd0;
      gcnt        <= 4'd0;
    end else begin
      out_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|input_req) begin
            owner     <= next_idx;
            out_sel   <= 4'hF - next_idx;
            out_grant <= 16'd1 << next_idx;
            out_busy  <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          // Select has had a full cycle to settle before enable rises.
          out_e <= 1'b1;
          timer <= 8'd1;
          state <= GRANT;
        end
        GRANT: begin
          if (grant_exit) begin
            out_e       <= 1'b0;
            out_grant   <= 16'd0;
            ptr         <= owner;
            timer       <= 8'd0;
            gcnt        <= 4'd1;
            out_timeout <= to_only;
            state       <= GUARD;
          end else if (timer != 8'hFF) begin
            timer <= timer + 8'd1;
          end
        end
        GUARD: begin
          if (gcnt >= GUARD_LAST) begin
            out_busy <= 1'b0;
            gcnt     <= 4'd0;
            state    <= IDLE;
          end else begin
            gcnt <= gcnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
